// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted store FIFO that drains onto AHB-Lite as NONSEQ
// single writes. Transfer size and byte address are recovered from the byte
// mask at enqueue time; address and data phases overlap, wait states stall
// the pipeline, and a two-cycle ERROR response is absorbed without retry.
module dmem_store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        wr_req_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  wr_mask_in,
  output logic        full_out,
  output logic        empty_out,
  output logic        illegal_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  input  logic        hready_in,
  input  logic        hresp_in,
  output logic        bus_err_out,
  output logic [31:0] err_addr_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10
  } state_e;

  // Mask decode: returns {legal, byte offset[1:0], hsize[2:0]}.
  function automatic logic [5:0] decode_mask(input logic [3:0] mask);
    logic [5:0] res;
    case (mask)
      4'b0001: res = {1'b1, 2'b00, 3'b000};
      4'b0010: res = {1'b1, 2'b01, 3'b000};
      4'b0100: res = {1'b1, 2'b10, 3'b000};
      4'b1000: res = {1'b1, 2'b11, 3'b000};
      4'b0011: res = {1'b1, 2'b00, 3'b001};
      4'b1100: res = {1'b1, 2'b10, 3'b001};
      4'b1111: res = {1'b1, 2'b00, 3'b010};
      default: res = {1'b0, 2'b00, 3'b010};
    endcase
    return res;
  endfunction

  // FIFO storage: byte address, size and lane data per entry
  logic [31:0]      addr_mem_q [DEPTH];
  logic [2:0]       size_mem_q [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic [31:0]      dp_addr_q, dp_addr_d;
  logic [31:0]      dp_data_q, dp_data_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [31:0]      err_addr_q, err_addr_d;

  logic [5:0]       dec_s;
  logic             legal_s;
  logic             push_s;
  logic             full_s;
  logic             fifo_empty_s;
  logic             nonseq_s;
  logic             accept_s;
  logic             err_done_s;
  logic             unused_s;

  assign unused_s     = ^addr_in[1:0];
  assign dec_s        = decode_mask(wr_mask_in);
  assign legal_s      = dec_s[5];
  assign full_s       = (count_q == CNT_W'(DEPTH));
  assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
  assign push_s       = wr_req_in && legal_s && !full_s;
  // The first ERROR cycle must suppress any new address, hence hresp_in here.
  assign nonseq_s     = !fifo_empty_s && (state_q != ST_ERR1) &&
                        !((state_q == ST_DATA) && hresp_in);
  assign accept_s     = nonseq_s && hready_in;
  assign err_done_s   = (state_q == ST_ERR1) && hready_in;

  // Controller next state: tracks the outstanding data phase and ERROR cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_DATA;
        else          state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (hready_in)     state_d = accept_s ? ST_DATA : ST_IDLE;
        else if (hresp_in) state_d = ST_ERR1;
        else               state_d = ST_DATA;
      end
      ST_ERR1: begin
        if (hready_in) state_d = ST_IDLE;
        else           state_d = ST_ERR1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: pointers, occupancy, data-phase register, pulses
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dp_addr_d  = dp_addr_q;
    dp_data_d  = dp_data_q;
    err_addr_d = err_addr_q;
    illegal_d  = wr_req_in && (wr_mask_in != 4'b0000) && !legal_s;
    bus_err_d  = err_done_s;
    if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else        wr_ptr_d = wr_ptr_q;
    if (accept_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      dp_addr_d = addr_mem_q[rd_ptr_q];
      dp_data_d = data_mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d  = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(push_s) - CNT_W'(accept_s);
    if (err_done_s) err_addr_d = dp_addr_q;
    else            err_addr_d = err_addr_q;
  end

  // Control and status registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      state_q    <= ST_IDLE;
      dp_addr_q  <= 32'h0000_0000;
      dp_data_q  <= 32'h0000_0000;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      dp_addr_q  <= dp_addr_d;
      dp_data_q  <= dp_data_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Entry storage; contents are only observed through valid pointers
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      addr_mem_q[wr_ptr_q] <= {addr_in[31:2], dec_s[4:3]};
      size_mem_q[wr_ptr_q] <= dec_s[2:0];
      data_mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign full_out     = full_s;
  assign empty_out    = fifo_empty_s && (state_q == ST_IDLE);
  assign illegal_out  = illegal_q;
  assign htrans_out   = nonseq_s ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite_out   = nonseq_s;
  assign haddr_out    = nonseq_s ? addr_mem_q[rd_ptr_q] : 32'h0000_0000;
  assign hsize_out    = nonseq_s ? size_mem_q[rd_ptr_q] : 3'b010;
  assign hwdata_out   = (state_q != ST_IDLE) ? dp_data_q : 32'h0000_0000;
  assign bus_err_out  = bus_err_q;
  assign err_addr_out = err_addr_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed test-plan steps followed by random
// traffic, all compared every cycle against a queue-level reference model.
module tb_dmem_store_buffer;

  localparam int DEPTH = 2;

  logic        clk_in = 1'b0;
  logic        rst_n_in, wr_req_in, hready_in, hresp_in;
  logic [31:0] addr_in, data_in;
  logic [3:0]  wr_mask_in;
  logic        full_out, empty_out, illegal_out, hwrite_out, bus_err_out;
  logic [31:0] haddr_out, hwdata_out, err_addr_out;
  logic [1:0]  htrans_out;
  logic [2:0]  hsize_out;

  int n_asserts = 0;
  int n_fail    = 0;

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .wr_req_in(wr_req_in),
    .addr_in(addr_in), .data_in(data_in), .wr_mask_in(wr_mask_in),
    .full_out(full_out), .empty_out(empty_out), .illegal_out(illegal_out),
    .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
    .hsize_out(hsize_out), .hwdata_out(hwdata_out), .hready_in(hready_in),
    .hresp_in(hresp_in), .bus_err_out(bus_err_out), .err_addr_out(err_addr_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: queue of pending stores plus one outstanding data phase
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_dp = 1'b0, m_err1 = 1'b0, m_ill = 1'b0, m_berr = 1'b0;
  logic        m_enq_last = 1'b0;
  logic [31:0] m_dp_addr = 32'h0, m_dp_data = 32'h0, m_eaddr = 32'h0;

  // Legal masks are one byte, an aligned halfword or the full word.
  function automatic logic mask_info(input logic [3:0] m, output logic [1:0] off,
                                     output logic [2:0] sz);
    int pc = 0;
    int lo = 4;
    logic [3:0] half = 4'b0011;
    for (int i = 3; i >= 0; i--) if (m[i]) begin pc++; lo = i; end
    off = (lo < 4) ? 2'(lo) : 2'b00;
    sz  = (pc == 4) ? 3'd2 : (pc == 2) ? 3'd1 : 3'd0;
    if (pc == 4) off = 2'b00;
    return (pc == 1) || (pc == 4) || (pc == 2 && (lo % 2) == 0 && m == (half << lo));
  endfunction

  function automatic logic m_nonseq();
    return (mq.size() > 0) && !m_err1 && !(m_dp && hresp_in);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output to the model, away from the rising edge
  task automatic sample();
    logic ns;
    @(negedge clk_in);
    ns = m_nonseq();
    chk("htrans",   32'(htrans_out), ns ? 32'd2 : 32'd0);
    chk("hwrite",   32'(hwrite_out), 32'(ns));
    chk("haddr",    haddr_out, ns ? mq[0].addr : 32'h0);
    chk("hsize",    32'(hsize_out), ns ? 32'(mq[0].size) : 32'd2);
    chk("hwdata",   hwdata_out, m_dp ? m_dp_data : 32'h0);
    chk("full",     32'(full_out), 32'(mq.size() == DEPTH));
    chk("empty",    32'(empty_out), 32'(mq.size() == 0 && !m_dp));
    chk("illegal",  32'(illegal_out), 32'(m_ill));
    chk("bus_err",  32'(bus_err_out), 32'(m_berr));
    chk("err_addr", err_addr_out, m_eaddr);
  endtask

  // Advance the model across the rising edge using the held inputs
  task automatic advance();
    logic ns, lg;
    logic [1:0] off;
    logic [2:0] sz;
    int pre_size;
    ent_t e;
    @(posedge clk_in);
    ns = m_nonseq();
    pre_size = mq.size();
    lg = mask_info(wr_mask_in, off, sz);
    m_enq_last = 1'b0;
    if (!rst_n_in) begin
      mq.delete();
      m_dp = 1'b0; m_err1 = 1'b0; m_ill = 1'b0; m_berr = 1'b0; m_eaddr = 32'h0;
    end else begin
      m_ill  = wr_req_in && (wr_mask_in != 4'b0000) && !lg;
      m_berr = 1'b0;
      if (m_dp && hready_in) begin
        if (m_err1) begin m_berr = 1'b1; m_eaddr = m_dp_addr; end
        m_dp = 1'b0; m_err1 = 1'b0;
      end else if (m_dp && !m_err1 && hresp_in) begin
        m_err1 = 1'b1;
      end
      if (ns && hready_in) begin
        e = mq.pop_front();
        m_dp = 1'b1; m_dp_addr = e.addr; m_dp_data = e.data;
      end
      if (wr_req_in && lg && pre_size < DEPTH) begin
        mq.push_back('{addr: {addr_in[31:2], off}, size: sz, data: data_in});
        m_enq_last = 1'b1;
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic set_req(input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
    wr_req_in = r; addr_in = a; data_in = d; wr_mask_in = m;
  endtask

  logic [3:0] masks [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                             4'b1100, 4'b1111, 4'b0000, 4'b0101, 4'b0110};

  initial begin
    logic got;
    logic err_next;
    rst_n_in = 1'b0; hready_in = 1'b1; hresp_in = 1'b0;
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    advance(); cycle();
    rst_n_in = 1'b1;
    sample();
    chk("rst_full", 32'(full_out), 32'd0);
    chk("rst_empty", 32'(empty_out), 32'd1);
    chk("rst_htrans", 32'(htrans_out), 32'd0);
    chk("rst_hsize", 32'(hsize_out), 32'd2);
    advance();

    // Single word store
    set_req(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b1111);
    cycle();
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    sample();
    chk("word_htrans", 32'(htrans_out), 32'd2);
    chk("word_haddr", haddr_out, 32'h1000_0004);
    chk("word_hsize", 32'(hsize_out), 32'd2);
    advance();
    sample();
    chk("word_hwdata", hwdata_out, 32'hDEAD_BEEF);
    advance();
    sample();
    chk("word_empty", 32'(empty_out), 32'd1);
    advance();

    // Byte and halfword decode, then an illegal mask
    set_req(1'b1, 32'h0000_0020, 32'h00AA_0000, 4'b0100);
    cycle();
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    sample();
    chk("byte_haddr", haddr_out, 32'h0000_0022);
    chk("byte_hsize", 32'(hsize_out), 32'd0);
    advance(); cycle(); cycle();
    set_req(1'b1, 32'h0000_0020, 32'hBBBB_0000, 4'b1100);
    cycle();
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    sample();
    chk("half_haddr", haddr_out, 32'h0000_0022);
    chk("half_hsize", 32'(hsize_out), 32'd1);
    advance(); cycle(); cycle();
    set_req(1'b1, 32'h0000_0030, 32'h1234_5678, 4'b0101);
    cycle();
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    sample();
    chk("illegal_pulse", 32'(illegal_out), 32'd1);
    chk("illegal_no_xfer", 32'(htrans_out), 32'd0);
    advance();
    sample();
    chk("illegal_once", 32'(illegal_out), 32'd0);
    advance();

    // Back-pressure: three stores while the bus stalls
    hready_in = 1'b0;
    set_req(1'b1, 32'h0000_0100, 32'h1111_1111, 4'b1111); cycle();
    set_req(1'b1, 32'h0000_0104, 32'h2222_2222, 4'b1111); cycle();
    set_req(1'b1, 32'h0000_0108, 32'h3333_3333, 4'b1111);
    sample();
    chk("bp_full", 32'(full_out), 32'd1);
    advance();
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) hready_in = 1'b1;
      cycle();
      if (m_enq_last) begin got = 1'b1; break; end
    end
    chk("bp_third_accepted", 32'(got), 32'd1);
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    for (int i = 0; i < 6; i++) cycle();

    // Wait states on the first of two back-to-back stores
    set_req(1'b1, 32'h0000_0200, 32'hAAAA_0001, 4'b1111); cycle();
    set_req(1'b1, 32'h0000_0204, 32'hAAAA_0002, 4'b0011); cycle();
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    hready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) hready_in = 1'b1;
      sample();
      chk("ws_haddr_hold", haddr_out, 32'h0000_0204);
      chk("ws_hwdata_hold", hwdata_out, 32'hAAAA_0001);
      advance();
    end
    sample();
    chk("ws_second_data", hwdata_out, 32'hAAAA_0002);
    advance();
    for (int i = 0; i < 3; i++) cycle();

    // ERROR response on the store at 0x40 with a second store queued
    set_req(1'b1, 32'h0000_0040, 32'hE000_0040, 4'b1111); cycle();
    set_req(1'b1, 32'h0000_0080, 32'hE000_0080, 4'b1111); cycle();
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    hresp_in = 1'b1; hready_in = 1'b0;
    sample();
    chk("err1_idle", 32'(htrans_out), 32'd0);
    advance();
    hready_in = 1'b1;
    sample();
    chk("err2_idle", 32'(htrans_out), 32'd0);
    chk("err2_no_pulse", 32'(bus_err_out), 32'd0);
    advance();
    hresp_in = 1'b0;
    sample();
    chk("err_pulse", 32'(bus_err_out), 32'd1);
    chk("err_addr", err_addr_out, 32'h0000_0040);
    chk("err_next_addr", haddr_out, 32'h0000_0080);
    advance();
    sample();
    chk("err_pulse_once", 32'(bus_err_out), 32'd0);
    advance();
    for (int i = 0; i < 3; i++) cycle();

    // Reset with two entries queued and a data phase pending
    set_req(1'b1, 32'h0000_0300, 32'h5555_0000, 4'b1111); cycle();
    set_req(1'b1, 32'h0000_0304, 32'h5555_0001, 4'b1111); cycle();
    hready_in = 1'b0;
    set_req(1'b1, 32'h0000_0308, 32'h5555_0002, 4'b1111); cycle();
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    rst_n_in = 1'b0; cycle();
    rst_n_in = 1'b1; hready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rstmid_htrans", 32'(htrans_out), 32'd0);
      chk("rstmid_empty", 32'(empty_out), 32'd1);
      chk("rstmid_hwdata", hwdata_out, 32'h0);
      chk("rstmid_err_addr", err_addr_out, 32'h0);
      advance();
    end

    // Random traffic with wait states and occasional ERROR responses
    err_next = 1'b0;
    for (int i = 0; i < 600; i++) begin
      set_req(1'($urandom_range(0, 1)), $urandom, $urandom, masks[$urandom_range(0, 9)]);
      if (err_next) begin
        hresp_in = 1'b1; hready_in = 1'b1; err_next = 1'b0;
      end else if (m_dp && !m_err1 && $urandom_range(0, 9) == 0) begin
        hresp_in = 1'b1; hready_in = 1'b0; err_next = 1'b1;
      end else begin
        hresp_in = 1'b0; hready_in = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    hresp_in = 1'b0; hready_in = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("final_drained", 32'(empty_out), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
